// File: rtl/controlador_entrada_pkg.sv
// Shared types and constants for the IN-instruction input responder.
package pacote_entrada;

   localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
   localparam int LARGURA_SWITCH_PADRAO  = 16;
   localparam int LARGURA_DADO_PADRAO    = 32;

   localparam logic [4:0] OPCODE_IN = 5'd19;

   typedef enum logic [2:0] {
      OCIOSO,
      ESPERA_SOLTAR,
      ESPERA_APERTO,
      DEBOUNCE,
      CAPTURA,
      ESCRITA
   } estado_t;

   // Operator-facing wait: any state where a press can still be accepted or aborted.
   function automatic logic estado_aguardando(input estado_t e);
      return (e == ESPERA_SOLTAR) || (e == ESPERA_APERTO) || (e == DEBOUNCE);
   endfunction

   function automatic logic estado_dado_valido(input estado_t e);
      return (e == CAPTURA) || (e == ESCRITA);
   endfunction

endpackage

// File: rtl/controlador_entrada_if.sv
// Board-pin / control-unit bundle of the input responder.
interface controlador_entrada_if import pacote_entrada::*; #(
   parameter int LARGURA_SWITCH = LARGURA_SWITCH_PADRAO,
   parameter int LARGURA_DADO   = LARGURA_DADO_PADRAO
);

   logic                      estagioEntradaUC;
   logic                      botao;
   logic [LARGURA_SWITCH-1:0] switches;
   logic                      estagioEntradaSwitch;
   logic                      estagioEntradaBanco;
   logic [LARGURA_DADO-1:0]   dadoSwitch;
   logic                      aguardando;

   modport master (
      output estagioEntradaUC,
      output botao,
      output switches,
      input  estagioEntradaSwitch,
      input  estagioEntradaBanco,
      input  dadoSwitch,
      input  aguardando
   );

   modport slave (
      input  estagioEntradaUC,
      input  botao,
      input  switches,
      output estagioEntradaSwitch,
      output estagioEntradaBanco,
      output dadoSwitch,
      output aguardando
   );

endinterface

// File: rtl/controlador_entrada_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; 2-cycle latency.
module sincronizador_2ff #(
   parameter int LARGURA = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] d,
   output logic [LARGURA-1:0] q
);

   logic [LARGURA-1:0] meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/controlador_entrada.sv
// Answers the IN-instruction stall: waits for a debounced button press, latches the
// switches and returns a data-valid pair plus a one-cycle register-bank write strobe.
module controlador_entrada import pacote_entrada::*; #(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
   parameter int LARGURA_SWITCH  = LARGURA_SWITCH_PADRAO,
   parameter int LARGURA_DADO    = LARGURA_DADO_PADRAO
) (
   input  logic                 clock,
   input  logic                 reset,
   controlador_entrada_if.slave io
);

   localparam int LARGURA_CONT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

   logic                      botao_sinc;
   logic [LARGURA_SWITCH-1:0] switches_sinc;

   estado_t                   estado, estado_prox;
   logic [LARGURA_CONT-1:0]   contador, contador_prox;

   logic                      dado_valido_q;
   logic                      banco_q;
   logic                      aguardando_q;
   logic [LARGURA_DADO-1:0]   dado_q;

   sincronizador_2ff #(.LARGURA(1)) u_sinc_botao (
      .clock (clock),
      .reset (reset),
      .d     (io.botao),
      .q     (botao_sinc)
   );

   sincronizador_2ff #(.LARGURA(LARGURA_SWITCH)) u_sinc_switches (
      .clock (clock),
      .reset (reset),
      .d     (io.switches),
      .q     (switches_sinc)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= OCIOSO;
         contador <= '0;
      end else begin
         estado   <= estado_prox;
         contador <= contador_prox;
      end
   end

   // Withdrawal of the request wins over any button activity while still waiting.
   always_comb begin
      estado_prox   = estado;
      contador_prox = contador;
      case (estado)
         OCIOSO: begin
            if (io.estagioEntradaUC) estado_prox = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (!io.estagioEntradaUC) estado_prox = OCIOSO;
            else if (!botao_sinc)     estado_prox = ESPERA_APERTO;
         end
         ESPERA_APERTO: begin
            if (!io.estagioEntradaUC) begin
               estado_prox = OCIOSO;
            end else if (botao_sinc) begin
               contador_prox = '0;
               estado_prox   = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!io.estagioEntradaUC)    estado_prox = OCIOSO;
            else if (!botao_sinc)        estado_prox = ESPERA_APERTO;
            else if (contador == CONT_MAX) estado_prox = CAPTURA;
            else                         contador_prox = contador + LARGURA_CONT'(1);
         end
         CAPTURA:  estado_prox = ESCRITA;
         ESCRITA:  estado_prox = ESPERA_SOLTAR;
         default:  estado_prox = OCIOSO;
      endcase
   end

   // Outputs are decoded from the next state so they are flops aligned with the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         aguardando_q  <= 1'b0;
         dado_valido_q <= 1'b0;
         banco_q       <= 1'b0;
         dado_q        <= '0;
      end else begin
         aguardando_q  <= estado_aguardando(estado_prox);
         dado_valido_q <= estado_dado_valido(estado_prox);
         banco_q       <= (estado_prox == ESCRITA);
         if (estado_prox == CAPTURA) dado_q <= LARGURA_DADO'(switches_sinc);
      end
   end

   assign io.aguardando           = aguardando_q;
   assign io.estagioEntradaSwitch = dado_valido_q;
   assign io.estagioEntradaBanco  = banco_q;
   assign io.dadoSwitch           = dado_q;

endmodule
